// File: rtl/systolic_gemm_tile.sv
// Output-stationary ROWS x COLS systolic GEMM tile: skewed A columns / B rows stream
// through a PE mesh, then accumulated rows are drained one beat at a time.
module systolic_gemm_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic [ACC_W-1:0]  load_val_i,
    input  logic              sat_en_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic              a_vld_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              b_vld_i,
    output logic [ACC_W-1:0]  acc_o
);
    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic        [ACC_W:0]   sum;
    logic        [ACC_W-1:0] sum_res, acc_q, acc_d;

    always_comb begin
        prod     = PW'($signed(a_i)) * PW'($signed(b_i));
        prod_ext = ACC_W'(prod);
        // One guard bit: overflow iff the two top bits disagree.
        sum      = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
        sum_res  = sum[ACC_W-1:0];
        if (sat_en_i && (sum[ACC_W] ^ sum[ACC_W-1]))
            sum_res = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        acc_d = acc_q;
        if (load_i)
            acc_d = load_val_i;
        else if (a_vld_i && b_vld_i)
            acc_d = sum_res;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) acc_q <= '0;
        else         acc_q <= acc_d;
    end

    assign acc_o = acc_q;
endmodule

module systolic_gemm_tile #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int K_MAX  = 16,
    localparam int KW    = $clog2(K_MAX + 1),
    localparam int RW    = $clog2(ROWS),
    localparam int FW    = $clog2(ROWS + COLS)
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                start_i,
    input  logic [KW-1:0]                       cfg_k_i,
    input  logic                                cfg_bias_en_i,
    input  logic                                cfg_sat_en_i,
    input  logic [ROWS-1:0][COLS-1:0][ACC_W-1:0] bias_data_i,
    input  logic [ROWS-1:0][DATA_W-1:0]         a_data_i,
    input  logic [COLS-1:0][DATA_W-1:0]         b_data_i,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    output logic [COLS-1:0][ACC_W-1:0]          res_data_o,
    output logic [RW-1:0]                       res_row_o,
    output logic                                res_valid_o,
    input  logic                                res_ready_i,
    output logic                                res_last_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                cfg_err_o
);
    typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d, beat_q, beat_d;
    logic [FW-1:0] flush_q, flush_d;
    logic [RW-1:0] row_q, row_d;
    logic          sat_q, sat_d, done_q, done_d, err_q, err_d;
    logic          load, fire, cfg_ok;

    assign fire   = in_valid_i && (state_q == S_FEED);
    assign cfg_ok = (cfg_k_i != '0) && (cfg_k_i <= KW'(K_MAX));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        sat_d   = sat_q;
        beat_d  = beat_q;
        flush_d = flush_q;
        row_d   = row_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load    = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                if (cfg_ok) begin
                    state_d = S_FEED;
                    k_d     = cfg_k_i;
                    sat_d   = cfg_sat_en_i;
                    beat_d  = '0;
                    load    = 1'b1;
                end else begin
                    err_d   = 1'b1;
                end
            end
            S_FEED: if (fire) begin
                beat_d = beat_q + KW'(1);
                if (beat_q + KW'(1) == k_q) begin
                    state_d = S_FLUSH;
                    flush_d = '0;
                end
            end
            S_FLUSH: begin
                // Last beat reaches PE(ROWS-1,COLS-1) ROWS+COLS-2 edges after acceptance.
                flush_d = flush_q + FW'(1);
                if (flush_q == FW'(ROWS + COLS - 2)) begin
                    state_d = S_DRAIN;
                    row_d   = '0;
                end
            end
            S_DRAIN: if (res_ready_i) begin
                if (row_q == RW'(ROWS - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    row_d   = '0;
                end else begin
                    row_d   = row_q + RW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            sat_q   <= 1'b0;
            beat_q  <= '0;
            flush_q <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            sat_q   <= sat_d;
            beat_q  <= beat_d;
            flush_q <= flush_d;
            row_q   <= row_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    logic [ROWS-1:0][DATA_W-1:0] a_sk;
    logic [ROWS-1:0]             av_sk;
    logic [COLS-1:0][DATA_W-1:0] b_sk;
    logic [COLS-1:0]             bv_sk;

    // Input skew: lane i is delayed i cycles; the valid tag is the accept strobe.
    for (genvar r = 0; r < ROWS; r++) begin : g_askew
        if (r == 0) begin : g_direct
            assign a_sk[0]  = a_data_i[0];
            assign av_sk[0] = fire;
        end else begin : g_dly
            logic [r-1:0][DATA_W-1:0] d_q;
            logic [r-1:0]             v_q;
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    d_q <= '0;
                    v_q <= '0;
                end else begin
                    d_q[0] <= a_data_i[r];
                    v_q[0] <= fire;
                    for (int j = 1; j < r; j++) begin
                        d_q[j] <= d_q[j-1];
                        v_q[j] <= v_q[j-1];
                    end
                end
            end
            assign a_sk[r]  = d_q[r-1];
            assign av_sk[r] = v_q[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_bskew
        if (c == 0) begin : g_direct
            assign b_sk[0]  = b_data_i[0];
            assign bv_sk[0] = fire;
        end else begin : g_dly
            logic [c-1:0][DATA_W-1:0] d_q;
            logic [c-1:0]             v_q;
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    d_q <= '0;
                    v_q <= '0;
                end else begin
                    d_q[0] <= b_data_i[c];
                    v_q[0] <= fire;
                    for (int j = 1; j < c; j++) begin
                        d_q[j] <= d_q[j-1];
                        v_q[j] <= v_q[j-1];
                    end
                end
            end
            assign b_sk[c]  = d_q[c-1];
            assign bv_sk[c] = v_q[c-1];
        end
    end

    logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] a_in, b_in;
    logic [ROWS-1:0][COLS-1:0]             av_in, bv_in;
    logic [ROWS-1:0][COLS-2:0][DATA_W-1:0] a_fwd_q;
    logic [ROWS-1:0][COLS-2:0]             av_fwd_q;
    logic [ROWS-2:0][COLS-1:0][DATA_W-1:0] b_fwd_q;
    logic [ROWS-2:0][COLS-1:0]             bv_fwd_q;
    logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]  acc;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_fwd_q  <= '0;
            av_fwd_q <= '0;
            b_fwd_q  <= '0;
            bv_fwd_q <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS - 1; c++) begin
                    a_fwd_q[r][c]  <= a_in[r][c];
                    av_fwd_q[r][c] <= av_in[r][c];
                end
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) begin
                    b_fwd_q[r][c]  <= b_in[r][c];
                    bv_fwd_q[r][c] <= bv_in[r][c];
                end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            if (c == 0) begin : g_aedge
                assign a_in[r][c]  = a_sk[r];
                assign av_in[r][c] = av_sk[r];
            end else begin : g_aint
                assign a_in[r][c]  = a_fwd_q[r][c-1];
                assign av_in[r][c] = av_fwd_q[r][c-1];
            end
            if (r == 0) begin : g_bedge
                assign b_in[r][c]  = b_sk[c];
                assign bv_in[r][c] = bv_sk[c];
            end else begin : g_bint
                assign b_in[r][c]  = b_fwd_q[r-1][c];
                assign bv_in[r][c] = bv_fwd_q[r-1][c];
            end

            systolic_gemm_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .clk_i      (clk_i),
                .reset_i    (reset_i),
                .load_i     (load),
                .load_val_i (cfg_bias_en_i ? bias_data_i[r][c] : '0),
                .sat_en_i   (sat_q),
                .a_i        (a_in[r][c]),
                .a_vld_i    (av_in[r][c]),
                .b_i        (b_in[r][c]),
                .b_vld_i    (bv_in[r][c]),
                .acc_o      (acc[r][c])
            );
        end
    end

    assign in_ready_o  = (state_q == S_FEED);
    assign res_valid_o = (state_q == S_DRAIN);
    assign res_last_o  = (state_q == S_DRAIN) && (row_q == RW'(ROWS - 1));
    assign res_row_o   = row_q;
    assign res_data_o  = (state_q == S_DRAIN) ? acc[row_q] : '0;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign cfg_err_o   = err_q;
endmodule

// File: tb/tb_systolic_gemm_tile.sv
// Randomised bench for systolic_gemm_tile against a plain matrix-multiply reference.
module tb_systolic_gemm_tile;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int KM = 16;
    localparam int KW = $clog2(KM + 1);
    localparam int RW = $clog2(R);

    logic                         clk = 1'b0;
    logic                         reset = 1'b1;
    logic                         start = 1'b0;
    logic [KW-1:0]                cfg_k = '0;
    logic                         cfg_bias_en = 1'b0;
    logic                         cfg_sat_en = 1'b0;
    logic [R-1:0][C-1:0][AW-1:0]  bias_data = '0;
    logic [R-1:0][DW-1:0]         a_data = '0;
    logic [C-1:0][DW-1:0]         b_data = '0;
    logic                         in_valid = 1'b0;
    logic                         in_ready;
    logic [C-1:0][AW-1:0]         res_data;
    logic [RW-1:0]                res_row;
    logic                         res_valid;
    logic                         res_ready = 1'b0;
    logic                         res_last;
    logic                         busy, done, cfg_err;

    systolic_gemm_tile #(.DATA_W(DW), .ACC_W(AW), .ROWS(R), .COLS(C), .K_MAX(KM)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .cfg_k_i(cfg_k),
        .cfg_bias_en_i(cfg_bias_en), .cfg_sat_en_i(cfg_sat_en), .bias_data_i(bias_data),
        .a_data_i(a_data), .b_data_i(b_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .res_data_o(res_data), .res_row_o(res_row), .res_valid_o(res_valid),
        .res_ready_i(res_ready), .res_last_o(res_last), .busy_o(busy), .done_o(done),
        .cfg_err_o(cfg_err)
    );

    always #5 clk = ~clk;

    int     cyc = 0;
    int     n_chk = 0, n_pass = 0;
    int     ga[R][KM];
    int     gb[KM][C];
    longint gbias[R][C];
    longint exp_c[R][C];
    int     tile_gen = 0;
    bit     exp_active = 1'b0;
    int     start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: bias (or 0) plus the k-ordered dot product, clamped or wrapped after each add.
    task automatic compute_model(input int k, input bit ben, input bit sat);
        longint hi, lo, m, acc;
        hi = (longint'(1) <<< (AW - 1)) - 1;
        lo = -(longint'(1) <<< (AW - 1));
        m  = longint'(1) <<< AW;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                acc = ben ? gbias[r][c] : 0;
                for (int kk = 0; kk < k; kk++) begin
                    acc = acc + longint'(ga[r][kk] * gb[kk][c]);
                    if (sat) begin
                        if (acc > hi) acc = hi;
                        if (acc < lo) acc = lo;
                    end else begin
                        acc = ((acc % m) + m) % m;
                        if (acc > hi) acc = acc - m;
                    end
                end
                exp_c[r][c] = acc;
            end
    endtask

    task automatic fill_rand();
        for (int r = 0; r < R; r++)
            for (int kk = 0; kk < KM; kk++) ga[r][kk] = int'($urandom_range(255)) - 128;
        for (int kk = 0; kk < KM; kk++)
            for (int c = 0; c < C; c++) gb[kk][c] = int'($urandom_range(255)) - 128;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) gbias[r][c] = longint'($urandom_range(65535)) - 32768;
    endtask

    task automatic start_tile(input int k, input bit ben, input bit sat);
        compute_model(k, ben, sat);
        tile_gen++;
        exp_active = 1'b1;
        cfg_k = KW'(k);
        cfg_bias_en = ben;
        cfg_sat_en = sat;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) bias_data[r][c] = gbias[r][c][AW-1:0];
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_in_ready", in_ready, 1);
        chk("done_one_cycle", done, 0);
    endtask

    // mode 0: no bubbles, 1: alternate valid/bubble, 2: random bubbles
    task automatic feed(input int k, input int mode);
        int kk = 0, guard = 0;
        bit ph = 1'b1, v;
        while (kk < k && guard < 400) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom_range(1));
            ph = ~ph;
            in_valid = v;
            for (int r = 0; r < R; r++) a_data[r] = ga[r][kk][DW-1:0];
            for (int c = 0; c < C; c++) b_data[c] = gb[kk][c][DW-1:0];
            if (v && in_ready) kk++;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        chk("beats_accepted", kk, k);
        chk("flush_not_ready", in_ready, 0);
    endtask

    // mode 0: always ready, 1: ready low 3 cycles per row, 2: random ready
    task automatic drain(input int k, input int mode, input bit chk_lat);
        int rows = 0, guard = 0, st = 0;
        bit seen = 1'b0;
        res_ready = (mode == 0);
        while (rows < R && guard < 2000) begin
            if (res_valid && !seen) begin
                seen = 1'b1;
                if (chk_lat) chk("first_result_latency", cyc - start_cyc, k + R + C);
            end
            if (mode == 1) begin
                res_ready = res_valid && (st >= 3);
                if (res_valid && st < 3) st++;
            end else if (mode == 2) begin
                res_ready = 1'($urandom_range(1));
            end
            if (res_valid && res_ready) begin
                rows++;
                st = 0;
            end
            tick();
            guard++;
        end
        chk("rows_drained", rows, R);
        chk("done_pulse", done, 1);
        chk("idle_after_done", busy, 0);
    endtask

    task automatic bad_start(input int k);
        cfg_k = KW'(k);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("cfg_err_pulse", cfg_err, 1);
        chk("cfg_err_not_busy", busy, 0);
        tick();
        chk("cfg_err_cleared", cfg_err, 0);
        chk("cfg_err_still_idle", busy, 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_last", res_last, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_row", res_row, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
    endtask

    // Compare process: every result-valid cycle is checked against the reference.
    int                   mon_gen = 0;
    int                   exp_row = 0;
    bit                   have_prev = 1'b0;
    logic [C-1:0][AW-1:0] prev_data, want_row;
    always @(negedge clk) begin
        if (mon_gen != tile_gen) begin
            mon_gen   = tile_gen;
            exp_row   = 0;
            have_prev = 1'b0;
        end
        if (!reset && res_valid) begin
            chk("result_expected", exp_active, 1);
            for (int c = 0; c < C; c++) want_row[c] = exp_c[exp_row % R][c][AW-1:0];
            chk("res_row", res_row, exp_row);
            chk("res_last", res_last, exp_row == R - 1);
            chk("res_data", res_data, want_row);
            if (have_prev) chk("stall_stable", res_data, prev_data);
            if (res_ready) begin
                exp_row++;
                have_prev = 1'b0;
            end else begin
                have_prev = 1'b1;
                prev_data = res_data;
            end
        end else begin
            have_prev = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk_reset_outputs();
        reset = 1'b0;
        tick();

        // Identity A passes B through unchanged.
        for (int r = 0; r < R; r++)
            for (int kk = 0; kk < KM; kk++) ga[r][kk] = (r == kk) ? 1 : 0;
        for (int kk = 0; kk < KM; kk++)
            for (int c = 0; c < C; c++) gb[kk][c] = kk * 4 + c;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) gbias[r][c] = 0;
        start_tile(4, 0, 0);
        chk("model_identity_r2c3", exp_c[2][3], 11);
        feed(4, 0);
        drain(4, 0, 1);

        // (-128)*(-128) + 5, started back-to-back in the done cycle.
        for (int r = 0; r < R; r++) ga[r][0] = -128;
        for (int c = 0; c < C; c++) gb[0][c] = -128;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) gbias[r][c] = 5;
        start_tile(1, 1, 0);
        chk("model_min_sq_bias", exp_c[1][2], 16389);
        feed(1, 0);
        drain(1, 0, 1);

        // Saturation versus wrap near the top of a 16-bit accumulator.
        for (int r = 0; r < R; r++)
            for (int kk = 0; kk < 4; kk++) ga[r][kk] = 2;
        for (int kk = 0; kk < 4; kk++)
            for (int c = 0; c < C; c++) gb[kk][c] = 2;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) gbias[r][c] = 32760;
        tick();
        start_tile(4, 1, 1);
        chk("model_sat", exp_c[3][3], 32767);
        feed(4, 0);
        drain(4, 0, 1);
        start_tile(4, 1, 0);
        chk("model_wrap", exp_c[0][0], -32760);
        feed(4, 0);
        drain(4, 0, 1);

        // Same data unstalled, then with bubbles and result back-pressure.
        fill_rand();
        tick();
        start_tile(16, 1, 1);
        feed(16, 0);
        drain(16, 0, 1);
        start_tile(16, 1, 1);
        feed(16, 1);
        drain(16, 1, 0);

        tick();
        bad_start(0);
        bad_start(17);

        // Reset mid-FLUSH, then a fresh tile must see none of the old operands.
        fill_rand();
        start_tile(6, 1, 0);
        feed(6, 0);
        tick();
        tick();
        exp_active = 1'b0;
        reset = 1'b1;
        tick();
        chk_reset_outputs();
        reset = 1'b0;
        fill_rand();
        start_tile(2, 0, 0);
        feed(2, 0);
        drain(2, 0, 1);

        for (int t = 0; t < 8; t++) begin
            int k;
            k = int'($urandom_range(KM, 1));
            fill_rand();
            start_tile(k, 1'($urandom_range(1)), 1'($urandom_range(1)));
            feed(k, 2);
            drain(k, 2, 0);
            if ($urandom_range(1) == 1) tick();
        end

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
